// File: rtl/axis_header_insert_arbiter_if.sv
// Header-request and inserter-side handshake bundle for the header insertion arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the surrounding sources and inserter.
interface axis_header_insert_arbiter_if #(
    parameter int DATA_WD = 32,
    parameter int NUM_SRC = 4
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

    logic [NUM_SRC-1:0]              req_valid;
    logic [NUM_SRC*DATA_WD-1:0]      req_data;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep;
    logic [NUM_SRC*BYTE_CNT_WD-1:0]  req_cnt;
    logic [NUM_SRC-1:0]              req_ready;
    logic                            ins_valid;
    logic [DATA_WD-1:0]              ins_data;
    logic [DATA_BYTE_WD-1:0]         ins_keep;
    logic [BYTE_CNT_WD-1:0]          ins_cnt;
    logic                            ins_ready;
    logic                            mon_valid;
    logic                            mon_ready;
    logic                            mon_last;

    modport master (
        input  req_valid, req_data, req_keep, req_cnt, ins_ready,
               mon_valid, mon_ready, mon_last,
        output req_ready, ins_valid, ins_data, ins_keep, ins_cnt
    );

    modport slave (
        output req_valid, req_data, req_keep, req_cnt, ins_ready,
               mon_valid, mon_ready, mon_last,
        input  req_ready, ins_valid, ins_data, ins_keep, ins_cnt
    );
endinterface

// File: rtl/axis_header_insert_arbiter.sv
// Round-robin arbiter sharing one header-insertion channel among NUM_SRC header sources.
// The grant is held until the inserter's output stream finishes the packet.
//
//   state | meaning
//   IDLE  | no grant held, pops the round-robin winner as soon as any request is valid
//   HDR   | latched header presented on ins_*, waiting for ins_ready
//   PKT   | header accepted, grant locked until last beat (or watchdog) on the monitor
module axis_header_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 4,
    parameter int SRC_WD       = $clog2(NUM_SRC),
    parameter int TIMEOUT_CYC  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_header_insert_arbiter_if.master  bus,
    output logic [SRC_WD-1:0]             grant_id,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int WD_WD = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_WD-1:0] WD_TOP   = WD_WD'(TIMEOUT_CYC);
    localparam logic [WD_WD-1:0] WD_LIMIT = (TIMEOUT_CYC > 0) ? WD_WD'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;

    state_t                  state_q, state_d;
    logic [SRC_WD-1:0]       last_ptr_q, grant_id_q, ptr_eff, winner;
    logic [DATA_WD-1:0]      ins_data_q;
    logic [DATA_BYTE_WD-1:0] ins_keep_q;
    logic [BYTE_CNT_WD-1:0]  ins_cnt_q;
    logic                    ins_valid_q, timeout_err_q;
    logic [WD_WD-1:0]        wd_cnt_q;
    logic                    any_req, mon_beat, eop, wd_hit, pop, wd_fire;
    int                      idx;

    assign any_req  = |bus.req_valid;
    assign mon_beat = bus.mon_valid && bus.mon_ready;
    assign eop      = (state_q == PKT) && mon_beat && bus.mon_last;
    assign wd_hit   = (TIMEOUT_CYC > 0) && (wd_cnt_q == WD_LIMIT) && !mon_beat;

    // The pointer update on end-of-packet is not visible yet, so the same-cycle pop scans from grant_id.
    always_comb begin
        ptr_eff = eop ? grant_id_q : last_ptr_q;
        winner  = '0;
        idx     = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = int'(ptr_eff) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (bus.req_valid[idx]) winner = idx[SRC_WD-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        wd_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    pop     = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (bus.ins_ready) state_d = PKT;
            end
            PKT: begin
                if (eop) begin
                    pop     = any_req;
                    state_d = any_req ? HDR : IDLE;
                end else if (wd_hit) begin
                    wd_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr_q    <= SRC_WD'(NUM_SRC - 1);
            grant_id_q    <= '0;
            ins_valid_q   <= 1'b0;
            ins_data_q    <= '0;
            ins_keep_q    <= '0;
            ins_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            timeout_err_q <= wd_fire;
            if (eop || wd_fire) last_ptr_q <= grant_id_q;
            if (pop) begin
                grant_id_q  <= winner;
                ins_valid_q <= 1'b1;
                ins_data_q  <= bus.req_data[int'(winner)*DATA_WD +: DATA_WD];
                ins_keep_q  <= bus.req_keep[int'(winner)*DATA_BYTE_WD +: DATA_BYTE_WD];
                ins_cnt_q   <= bus.req_cnt[int'(winner)*BYTE_CNT_WD +: BYTE_CNT_WD];
            end else if (state_q == HDR && bus.ins_ready) begin
                ins_valid_q <= 1'b0;
            end
            // Cleared outside PKT so every PKT entry starts from zero. The counter saturates instead of wrapping.
            if (state_q != PKT || mon_beat) wd_cnt_q <= '0;
            else if (wd_cnt_q != WD_TOP)    wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign bus.req_ready = pop ? (NUM_SRC'(1) << winner) : '0;
    assign bus.ins_valid = ins_valid_q;
    assign bus.ins_data  = ins_data_q;
    assign bus.ins_keep  = ins_keep_q;
    assign bus.ins_cnt   = ins_cnt_q;
    assign grant_id      = grant_id_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = timeout_err_q;
endmodule
